// File: rtl/clause_bank_pkg.sv
// Shared types and helpers for the clause register bank.
// Contents:
//   scan_state_t        - scan engine states (IDLE/SCAN/HOLD/DONE)
//   clause_vec_t        - clause coefficient vector at the default geometry
//   clause_index_width  - index width needed to address n entries
package clause_bank_pkg;

    localparam int unsigned DEFAULT_BIT_WIDTH_OF_INTEGER_VARIABLE = 2;
    localparam int unsigned DEFAULT_NUMBER_OF_INTEGER_VARIABLES   = 2;
    localparam int unsigned DEFAULT_COEFF_W =
        DEFAULT_BIT_WIDTH_OF_INTEGER_VARIABLE * DEFAULT_NUMBER_OF_INTEGER_VARIABLES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    typedef logic [DEFAULT_COEFF_W-1:0] clause_vec_t;

    // Never narrower than one bit so a degenerate depth still has a legal port.
    function automatic int unsigned clause_index_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clause_scan_fsm.sv
// Scan engine: walks the pointer over the bank, presents valid entries over a
// valid/ready handshake and signals the end of a sweep.
// Ports:
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   i_scan_start     - begin a sweep (honoured in IDLE only)
//   i_scan_ready     - downstream accepts the presented clause
//   i_entry_ok       - entry under the pointer may be presented
//   o_ptr            - current scan pointer (addresses storage)
//   o_load_c         - combinational: capture entry data this cycle
//   o_scan_valid     - presented clause is valid
//   o_scan_index     - index of presented clause
//   o_scan_done      - one-cycle end-of-sweep pulse
//   o_busy           - sweep in progress (SCAN/HOLD)
module clause_scan_fsm
    import clause_bank_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned IDX_W       = 2
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_scan_start,
    input  logic             i_scan_ready,
    input  logic             i_entry_ok,
    output logic [IDX_W-1:0] o_ptr,
    output logic             o_load_c,
    output logic             o_scan_valid,
    output logic [IDX_W-1:0] o_scan_index,
    output logic             o_scan_done,
    output logic             o_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             r_scan_valid;
    logic             w_scan_valid_nxt;
    logic [IDX_W-1:0] r_scan_index;
    logic [IDX_W-1:0] w_scan_index_nxt;
    logic             r_scan_done;
    logic             w_scan_done_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             w_load;
    logic             w_ptr_last;

    assign w_ptr_last = (r_ptr == LAST_IDX);

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_scan_valid <= 1'b0;
            r_scan_index <= '0;
            r_scan_done  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_scan_valid <= w_scan_valid_nxt;
            r_scan_index <= w_scan_index_nxt;
            r_scan_done  <= w_scan_done_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_scan_valid_nxt = r_scan_valid;
        w_scan_index_nxt = r_scan_index;
        w_load           = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_scan_start) begin
                    w_state_nxt = SCAN;
                    w_ptr_nxt   = '0;
                end
            end
            SCAN: begin
                if (i_entry_ok) begin
                    w_load           = 1'b1;
                    w_scan_valid_nxt = 1'b1;
                    w_scan_index_nxt = r_ptr;
                    w_state_nxt      = HOLD;
                end else if (w_ptr_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_ptr_nxt = r_ptr + IDX_W'(1);
                end
            end
            HOLD: begin
                if (i_scan_ready) begin
                    w_scan_valid_nxt = 1'b0;
                    if (w_ptr_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_ptr_nxt   = r_ptr + IDX_W'(1);
                        w_state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // DONE lasts exactly one cycle, so entering it yields a single pulse.
        w_scan_done_nxt = (w_state_nxt == DONE);
        w_busy_nxt      = (w_state_nxt == SCAN) || (w_state_nxt == HOLD);
    end

    assign o_ptr        = r_ptr;
    assign o_load_c     = w_load;
    assign o_scan_valid = r_scan_valid;
    assign o_scan_index = r_scan_index;
    assign o_scan_done  = r_scan_done;
    assign o_busy       = r_busy;

endmodule

// File: rtl/clause_register_bank.sv
// Indexed bank of clause-coefficient vectors with per-entry valid bits and a
// scan engine that streams valid clauses in ascending index order.
// Optional feature macro: CLAUSE_BANK_PARITY_EN (per-entry even parity,
// corrupted entries are skipped, invalidated and reported on out_parity_error).
// Ports:
//   in_clk, in_reset         - clock, asynchronous active-low reset
//   in_write_enable          - write strobe
//   in_write_index           - target entry
//   in_clause_coefficients   - data written
//   in_invalidate            - with write strobe: clear valid bit only
//   in_scan_start            - begin sweep
//   in_scan_ready            - downstream accepts presented clause
//   out_scan_valid           - presented clause valid
//   out_scan_index           - index of presented clause
//   out_clause_coefficients  - presented clause (held when not valid)
//   out_scan_done            - end-of-sweep pulse
//   out_busy                 - sweep in progress
//   out_valid_mask           - per-entry valid bits
//   out_write_dropped        - write rejected pulse
//   out_parity_error         - parity-failure pulse (CLAUSE_BANK_PARITY_EN only)
module clause_register_bank
    import clause_bank_pkg::*;
#(
    parameter  int unsigned BIT_WIDTH_OF_INTEGER_VARIABLE = 2,
    parameter  int unsigned NUMBER_OF_INTEGER_VARIABLES   = 2,
    parameter  int unsigned NUMBER_OF_CLAUSES             = 4,
    localparam int unsigned CLAUSE_INDEX_WIDTH = clause_index_width(NUMBER_OF_CLAUSES),
    localparam int unsigned COEFF_W =
        BIT_WIDTH_OF_INTEGER_VARIABLE * NUMBER_OF_INTEGER_VARIABLES
)(
    input  logic                          in_clk,
    input  logic                          in_reset,
    input  logic                          in_write_enable,
    input  logic [CLAUSE_INDEX_WIDTH-1:0] in_write_index,
    input  logic [COEFF_W-1:0]            in_clause_coefficients,
    input  logic                          in_invalidate,
    input  logic                          in_scan_start,
    input  logic                          in_scan_ready,
    output logic                          out_scan_valid,
    output logic [CLAUSE_INDEX_WIDTH-1:0] out_scan_index,
    output logic [COEFF_W-1:0]            out_clause_coefficients,
    output logic                          out_scan_done,
    output logic                          out_busy,
    output logic [NUMBER_OF_CLAUSES-1:0]  out_valid_mask,
    output logic                          out_write_dropped
`ifdef CLAUSE_BANK_PARITY_EN
    ,
    output logic                          out_parity_error
`endif
);

    logic [COEFF_W-1:0]            r_mem [NUMBER_OF_CLAUSES];
    logic [NUMBER_OF_CLAUSES-1:0]  r_valid_mask;
    logic [COEFF_W-1:0]            r_coeff;
    logic                          r_write_dropped;

    logic                          w_index_in_range;
    logic                          w_write_accept;
    logic                          w_write_drop;
    logic                          w_entry_ok;
    logic [CLAUSE_INDEX_WIDTH-1:0] w_ptr;
    logic                          w_load_c;
    logic                          w_scan_valid;
    logic                          w_busy;

    // Index range decode; only matters when the depth is not a power of two.
    always_comb begin
        w_index_in_range = 1'b0;
        for (int i = 0; i < int'(NUMBER_OF_CLAUSES); i++) begin
            if (in_write_index == CLAUSE_INDEX_WIDTH'(i)) begin
                w_index_in_range = 1'b1;
            end
        end
    end

    // Storage is frozen for the whole sweep so the scan sees a stable snapshot.
    assign w_write_accept = in_write_enable && !w_busy && w_index_in_range;
    assign w_write_drop   = in_write_enable && (w_busy || !w_index_in_range);

`ifdef CLAUSE_BANK_PARITY_EN
    logic [NUMBER_OF_CLAUSES-1:0] r_parity;
    logic                         r_parity_error;
    logic                         w_scanning;
    logic                         w_parity_bad;
    logic                         w_parity_err;

    // SCAN is the only busy state with nothing presented.
    assign w_scanning   = w_busy && !w_scan_valid;
    assign w_parity_bad = (^r_mem[w_ptr]) ^ r_parity[w_ptr];
    assign w_parity_err = w_scanning && r_valid_mask[w_ptr] && w_parity_bad;
    assign w_entry_ok   = r_valid_mask[w_ptr] && !w_parity_bad;

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_parity       <= '0;
            r_parity_error <= 1'b0;
        end else begin
            r_parity_error <= w_parity_err;
            if (w_write_accept && !in_invalidate) begin
                r_parity[in_write_index] <= ^in_clause_coefficients;
            end
        end
    end

    assign out_parity_error = r_parity_error;
`else
    assign w_entry_ok = r_valid_mask[w_ptr];
`endif

    // Clause storage, valid bits and write-reject pulse.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            for (int i = 0; i < int'(NUMBER_OF_CLAUSES); i++) begin
                r_mem[i] <= '0;
            end
            r_valid_mask    <= '0;
            r_write_dropped <= 1'b0;
        end else begin
            r_write_dropped <= w_write_drop;
            if (w_write_accept) begin
                if (in_invalidate) begin
                    r_valid_mask[in_write_index] <= 1'b0;
                end else begin
                    r_mem[in_write_index]        <= in_clause_coefficients;
                    r_valid_mask[in_write_index] <= 1'b1;
                end
            end
`ifdef CLAUSE_BANK_PARITY_EN
            if (w_parity_err) begin
                r_valid_mask[w_ptr] <= 1'b0;
            end
`endif
        end
    end

    // Presented clause data; holds its last value between presentations.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_coeff <= '0;
        end else if (w_load_c) begin
            r_coeff <= r_mem[w_ptr];
        end
    end

    clause_scan_fsm #(
        .NUM_ENTRIES (NUMBER_OF_CLAUSES),
        .IDX_W       (CLAUSE_INDEX_WIDTH)
    ) u_scan_fsm (
        .i_clk        (in_clk),
        .i_rst_n      (in_reset),
        .i_scan_start (in_scan_start),
        .i_scan_ready (in_scan_ready),
        .i_entry_ok   (w_entry_ok),
        .o_ptr        (w_ptr),
        .o_load_c     (w_load_c),
        .o_scan_valid (w_scan_valid),
        .o_scan_index (out_scan_index),
        .o_scan_done  (out_scan_done),
        .o_busy       (w_busy)
    );

    assign out_scan_valid          = w_scan_valid;
    assign out_busy                = w_busy;
    assign out_clause_coefficients = r_coeff;
    assign out_valid_mask          = r_valid_mask;
    assign out_write_dropped       = r_write_dropped;

endmodule

// File: tb/tb_clause_register_bank.sv
// Self-checking bench for clause_register_bank at the default geometry
// (4 clauses, 4-bit clause vectors). Table-driven vectors for the write/scan
// flows plus hand-written sequences for empty-bank latency and reset mid-scan.
module tb_clause_register_bank;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 4;

    logic          in_clk;
    logic          in_reset;
    logic          in_write_enable;
    logic [IW-1:0] in_write_index;
    logic [CW-1:0] in_clause_coefficients;
    logic          in_invalidate;
    logic          in_scan_start;
    logic          in_scan_ready;
    logic          out_scan_valid;
    logic [IW-1:0] out_scan_index;
    logic [CW-1:0] out_clause_coefficients;
    logic          out_scan_done;
    logic          out_busy;
    logic [N-1:0]  out_valid_mask;
    logic          out_write_dropped;
`ifdef CLAUSE_BANK_PARITY_EN
    logic          out_parity_error;
`endif

    int n_checks = 0;
    int n_errors = 0;

    clause_register_bank dut (
        .in_clk                  (in_clk),
        .in_reset                (in_reset),
        .in_write_enable         (in_write_enable),
        .in_write_index          (in_write_index),
        .in_clause_coefficients  (in_clause_coefficients),
        .in_invalidate           (in_invalidate),
        .in_scan_start           (in_scan_start),
        .in_scan_ready           (in_scan_ready),
        .out_scan_valid          (out_scan_valid),
        .out_scan_index          (out_scan_index),
        .out_clause_coefficients (out_clause_coefficients),
        .out_scan_done           (out_scan_done),
        .out_busy                (out_busy),
        .out_valid_mask          (out_valid_mask),
        .out_write_dropped       (out_write_dropped)
`ifdef CLAUSE_BANK_PARITY_EN
        ,
        .out_parity_error        (out_parity_error)
`endif
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic          we;
        logic [IW-1:0] idx;
        logic [CW-1:0] coef;
        logic          inval;
        logic          start;
        logic          ready;
        logic          e_valid;
        logic [IW-1:0] e_idx;
        logic [CW-1:0] e_coef;
        logic          e_done;
        logic          e_busy;
        logic [N-1:0]  e_mask;
        logic          e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic we, input logic [IW-1:0] idx, input logic [CW-1:0] coef,
        input logic inval, input logic start, input logic ready,
        input logic e_valid, input logic [IW-1:0] e_idx, input logic [CW-1:0] e_coef,
        input logic e_done, input logic e_busy, input logic [N-1:0] e_mask,
        input logic e_drop);
        vec_t v;
        v.we = we; v.idx = idx; v.coef = coef; v.inval = inval;
        v.start = start; v.ready = ready;
        v.e_valid = e_valid; v.e_idx = e_idx; v.e_coef = e_coef;
        v.e_done = e_done; v.e_busy = e_busy; v.e_mask = e_mask; v.e_drop = e_drop;
        return v;
    endfunction

    // {valid, index, coef, done, busy, mask, dropped}
    function automatic logic [13:0] dut_pack();
        return {out_scan_valid, out_scan_index, out_clause_coefficients,
                out_scan_done, out_busy, out_valid_mask, out_write_dropped};
    endfunction

    task automatic check_vec(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b want %b (valid,idx,coef,done,busy,mask,drop)",
                     name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_write_enable        = 1'b0;
        in_write_index         = '0;
        in_clause_coefficients = '0;
        in_invalidate          = 1'b0;
        in_scan_start          = 1'b0;
        in_scan_ready          = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        in_reset = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        in_reset = 1'b1;
    endtask

    task automatic apply(input vec_t v, input string name);
        in_write_enable        = v.we;
        in_write_index         = v.idx;
        in_clause_coefficients = v.coef;
        in_invalidate          = v.inval;
        in_scan_start          = v.start;
        in_scan_ready          = v.ready;
        @(posedge in_clk);
        #1;
        check_vec(name, dut_pack(),
                  {v.e_valid, v.e_idx, v.e_coef, v.e_done, v.e_busy, v.e_mask, v.e_drop});
    endtask

    initial begin
        int  done_at;
        bit  saw_valid;
        bit  saw_done;
        bit  saw_busy;

        // Flow A: fill idx0/idx2, sweep with ready held high.
        vecs.push_back(mk(1,0,4'h1,0,0,1, 0,0,4'h0,0,0,4'b0001,0));
        vecs.push_back(mk(1,2,4'h7,0,0,1, 0,0,4'h0,0,0,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,1,1, 0,0,4'h0,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 1,0,4'h1,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,0,4'h1,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,0,4'h1,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 1,2,4'h7,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,2,4'h7,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,2,4'h7,1,0,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,2,4'h7,0,0,4'b0101,0));
        // Flow B: backpressure for 5+ cycles at idx0, then a write while busy.
        vecs.push_back(mk(0,0,4'h0,0,1,0, 0,2,4'h7,0,1,4'b0101,0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(0,0,4'h0,0,0,0, 1,0,4'h1,0,1,4'b0101,0));
        vecs.push_back(mk(1,1,4'h9,0,0,1, 0,0,4'h1,0,1,4'b0101,1));
        vecs.push_back(mk(0,0,4'h0,0,0,0, 0,0,4'h1,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,0, 1,2,4'h7,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,2,4'h7,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,0, 0,2,4'h7,1,0,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,0, 0,2,4'h7,0,0,4'b0101,0));
        // Flow C: write idx3 then invalidate it; sweep must skip idx3.
        vecs.push_back(mk(1,3,4'h8,0,0,1, 0,2,4'h7,0,0,4'b1101,0));
        vecs.push_back(mk(1,3,4'hF,1,0,1, 0,2,4'h7,0,0,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,1,1, 0,2,4'h7,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 1,0,4'h1,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,0,4'h1,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,0,4'h1,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 1,2,4'h7,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,2,4'h7,0,1,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,2,4'h7,1,0,4'b0101,0));
        vecs.push_back(mk(0,0,4'h0,0,0,1, 0,2,4'h7,0,0,4'b0101,0));

        // Reset state, checked while reset is held.
        idle_inputs();
        in_reset = 1'b1;
        #2;
        in_reset = 1'b0;
        #1;
        check_vec("reset_async", dut_pack(), 14'b0);
        @(posedge in_clk);
        #1;
        check_vec("reset_held", dut_pack(), 14'b0);
        in_reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end
        idle_inputs();

        // Empty bank: done N+1 cycles after the start cycle, nothing presented.
        do_reset();
        in_scan_start = 1'b1;
        done_at   = -1;
        saw_valid = 1'b0;
        for (int k = 1; k <= 2 * int'(N) + 4; k++) begin
            @(posedge in_clk);
            #1;
            in_scan_start = 1'b0;
            if (out_scan_valid) saw_valid = 1'b1;
            if (out_scan_done && done_at < 0) done_at = k;
        end
        check_int("empty_done_latency", done_at, int'(N) + 1);
        check_int("empty_no_valid", int'(saw_valid), 0);
        check_vec("empty_idle_after", dut_pack(), 14'b0);

        // Reset asserted while presenting idx0 in HOLD.
        do_reset();
        in_write_enable        = 1'b1;
        in_write_index         = 2'd0;
        in_clause_coefficients = 4'h1;
        @(posedge in_clk);
        #1;
        idle_inputs();
        in_scan_start = 1'b1;
        @(posedge in_clk);
        #1;
        in_scan_start = 1'b0;
        @(posedge in_clk);
        #1;
        check_vec("rst_pre_hold", dut_pack(), {1'b1, 2'd0, 4'h1, 1'b0, 1'b1, 4'b0001, 1'b0});
        #2;
        in_reset = 1'b0;
        #1;
        check_vec("rst_mid_scan", dut_pack(), 14'b0);
        @(negedge in_clk);
        in_reset = 1'b1;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge in_clk);
            #1;
            if (out_scan_done) saw_done = 1'b1;
            if (out_busy) saw_busy = 1'b1;
        end
        check_int("rst_no_done", int'(saw_done), 0);
        check_int("rst_stays_idle", int'(saw_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clause_register_bank.md
Name: clause_register_bank

Overview:
Parametrised successor to the single clause register. Holds NUMBER_OF_CLAUSES clause-coefficient vectors, each with a per-entry valid bit, writable by index. A scan engine streams every valid clause, in ascending index order, to the downstream constraint evaluator over a valid/ready handshake. Sits between the host-side clause loader and the MCMC clause-evaluation pipeline.

Parameters:
BIT_WIDTH_OF_INTEGER_VARIABLE, 2, bits per coefficient (two's complement)
NUMBER_OF_INTEGER_VARIABLES, 2, coefficients per clause
NUMBER_OF_CLAUSES, 4, storage depth; must be >= 2
CLAUSE_INDEX_WIDTH, $clog2(NUMBER_OF_CLAUSES), index width; derived, not overridden
COEFF_W (localparam), BIT_WIDTH_OF_INTEGER_VARIABLE*NUMBER_OF_INTEGER_VARIABLES, clause vector width

Ports:
in_clk  input  1  clock, rising edge
in_reset  input  1  asynchronous, active-low reset
in_write_enable  input  1  write strobe
in_write_index  input  CLAUSE_INDEX_WIDTH  target entry
in_clause_coefficients  input  COEFF_W  data written
in_invalidate  input  1  with in_write_enable: clear the entry's valid bit instead of writing data
in_scan_start  input  1  single-cycle pulse: begin sweep
in_scan_ready  input  1  downstream accepts current clause
out_scan_valid  output  1  out_clause_coefficients/out_scan_index valid
out_scan_index  output  CLAUSE_INDEX_WIDTH  index of presented clause
out_clause_coefficients  output  COEFF_W  presented clause
out_scan_done  output  1  one-cycle pulse at end of sweep
out_busy  output  1  high in SCAN/HOLD
out_valid_mask  output  NUMBER_OF_CLAUSES  per-entry valid bits
out_write_dropped  output  1  one-cycle pulse: write rejected

Behaviour:
- Reset (in_reset=0, async): storage cleared to 0, valid mask 0, FSM IDLE, pointer 0, all outputs 0.
- Write in IDLE: on the clock edge, entry[in_write_index] <= data and valid <= 1. With in_invalidate=1, valid <= 0 and data is unchanged. Index >= NUMBER_OF_CLAUSES: ignored, out_write_dropped pulses.
- Write while out_busy=1: ignored; out_write_dropped pulses next cycle.
- FSM states: IDLE, SCAN, HOLD, DONE.
- IDLE -> SCAN on in_scan_start; pointer <= 0. in_scan_start while busy is ignored.
- SCAN examines one entry per cycle.
  - Entry valid: register the data and index onto the outputs, set out_scan_valid, go to HOLD.
  - Entry invalid: pointer++ with no output change.
  - Pointer at NUMBER_OF_CLAUSES-1 with no valid entry: go to DONE.
- HOLD: outputs stable while in_scan_ready=0.
  - On in_scan_ready=1: out_scan_valid drops next cycle; pointer++; back to SCAN, or DONE if the last index was presented.
  - Minimum throughput is one clause per 2 cycles.
- DONE: out_scan_done=1 for one cycle -> IDLE.
- Empty mask: start -> DONE after NUMBER_OF_CLAUSES SCAN cycles.
- Latency: start at cycle t, entry 0 valid -> out_scan_valid at t+2.
- Reset mid-scan: immediate return to IDLE, all state cleared, no done pulse.
- Outputs are registered. out_clause_coefficients holds its last value when out_scan_valid=0.

Optional Feature:
Macro CLAUSE_BANK_PARITY_EN.
- Defined: each entry stores an even-parity bit computed at write. During SCAN, a parity mismatch on a valid entry makes the engine skip that entry and pulse extra output out_parity_error (1 bit); the valid bit is cleared.
- Undefined: no parity storage, and the port is absent.

Decomposition:
- Package clause_bank_pkg: FSM state enum (IDLE/SCAN/HOLD/DONE), typedef for clause vector, index width function.
- Sub-module clause_scan_fsm: pointer, state, handshake. Storage and write decode stay in the top.

Test Plan:
- Reset, write idx0=4'h1, idx2=4'h7, start scan, ready=1 -> valid at idx0 (0x1), then idx2 (0x7), done pulse; mask=4'b0101.
- Same contents, ready held 0 for 5 cycles at idx0 -> outputs stable at 0x1/idx0 for all 5, no pointer advance.
- Write idx1=4'h9 during busy -> write_dropped pulse, mask unchanged, idx1 absent from sweep.
- Empty bank, start -> no out_scan_valid, done pulse exactly NUMBER_OF_CLAUSES+1 cycles after start.
- Assert in_reset=0 while in HOLD -> out_scan_valid=0 and busy=0 immediately, mask=0, no done.
- Write idx3=4'h8 then invalidate idx3 -> mask bit3=0, sweep skips idx3.
